// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers ALU/memory/multiplier register writes in per-source FIFOs
// and drains them onto a single register-file write port (fixed priority + starvation override).
module wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [ADDR_W-1:0] alu_addr_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic              mem_valid_i,
  output logic              mem_ready_o,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mul_valid_i,
  output logic              mul_ready_o,
  input  logic [ADDR_W-1:0] mul_addr_i,
  input  logic [DATA_W-1:0] mul_data_i,
  output logic              writeEn_o,
  output logic [ADDR_W-1:0] dest_addr_o,
  output logic [DATA_W-1:0] writeVal_o
);

  localparam int NSRC = 3;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int SW   = $clog2(STARVE_MAX + 1);
  localparam int EW   = ADDR_W + DATA_W;

  // Source index 0 = mem, 1 = alu, 2 = mul, so lower index means higher priority.
  logic [NSRC-1:0] src_valid;
  logic [NSRC-1:0] src_ready;
  logic [NSRC-1:0] nonempty;
  logic [NSRC-1:0] starved;
  logic [NSRC-1:0] grant;
  logic [EW-1:0]   src_entry [NSRC];
  logic [EW-1:0]   head      [NSRC];
  logic [EW-1:0]   sel_entry;

  logic              write_en_q, write_en_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] val_q, val_d;

  assign src_valid    = {mul_valid_i, alu_valid_i, mem_valid_i};
  assign src_entry[0] = {mem_addr_i, mem_data_i};
  assign src_entry[1] = {alu_addr_i, alu_data_i};
  assign src_entry[2] = {mul_addr_i, mul_data_i};

  assign mem_ready_o = src_ready[0];
  assign alu_ready_o = src_ready[1];
  assign mul_ready_o = src_ready[2];

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      logic [EW-1:0] fifo_q [FIFO_DEPTH];
      logic [PW-1:0] rd_ptr_q;
      logic [PW-1:0] wr_ptr_q;
      logic [PW:0]   count_q;
      logic [SW-1:0] starve_q;
      logic          push;
      logic          pop;

      // Ready depends only on registered occupancy, never on this cycle's pop.
      assign src_ready[gi] = reset_i && (count_q < (PW+1)'(FIFO_DEPTH));
      assign nonempty[gi]  = (count_q != '0);
      assign starved[gi]   = nonempty[gi] && (starve_q == SW'(STARVE_MAX));
      assign head[gi]      = fifo_q[rd_ptr_q];
      assign push          = src_valid[gi] && src_ready[gi] && !flush_i;
      assign pop           = grant[gi] && !flush_i;

      always_ff @(posedge clock_i) begin
        if (push) begin
          fifo_q[wr_ptr_q] <= src_entry[gi];
        end
      end

      always_ff @(posedge clock_i) begin
        if (!reset_i || flush_i) begin
          rd_ptr_q <= '0;
          wr_ptr_q <= '0;
          count_q  <= '0;
          starve_q <= '0;
        end else begin
          if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
          if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
          case ({push, pop})
            2'b10:   count_q <= count_q + (PW+1)'(1);
            2'b01:   count_q <= count_q - (PW+1)'(1);
            default: count_q <= count_q;
          endcase
          if (!nonempty[gi] || grant[gi]) begin
            starve_q <= '0;
          end else if (starve_q != SW'(STARVE_MAX)) begin
            starve_q <= starve_q + SW'(1);
          end
        end
      end
    end
  endgenerate

  always_comb begin
    grant = '0;
    if      (starved[0])  grant = 3'b001;
    else if (starved[1])  grant = 3'b010;
    else if (starved[2])  grant = 3'b100;
    else if (nonempty[0]) grant = 3'b001;
    else if (nonempty[1]) grant = 3'b010;
    else if (nonempty[2]) grant = 3'b100;
  end

  always_comb begin
    sel_entry = head[0];
    if (grant[1]) sel_entry = head[1];
    if (grant[2]) sel_entry = head[2];
  end

  // Address/data hold their last value while idle; only writeEn drops.
  always_comb begin
    write_en_d = 1'b0;
    dest_d     = dest_q;
    val_d      = val_q;
    if ((grant != '0) && !flush_i) begin
      write_en_d      = 1'b1;
      {dest_d, val_d} = sel_entry;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      write_en_q <= 1'b0;
      dest_q     <= '0;
      val_q      <= '0;
    end else begin
      write_en_q <= write_en_d;
      dest_q     <= dest_d;
      val_q      <= val_d;
    end
  end

  assign writeEn_o   = write_en_q;
  assign dest_addr_o = dest_q;
  assign writeVal_o  = val_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: queue-based reference model predicts each register
// write and its cycle; a monitor pops and compares whenever writeEn is seen.
module tb_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 2;
  localparam int SM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          flush;
  logic          v [3];
  logic [AW-1:0] a [3];
  logic [DW-1:0] d [3];
  logic          mem_ready, alu_ready, mul_ready;
  logic          we;
  logic [AW-1:0] dest;
  logic [DW-1:0] val;

  wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(D), .STARVE_MAX(SM)) dut (
    .clock_i(clk), .reset_i(rst_n), .flush_i(flush),
    .alu_valid_i(v[1]), .alu_ready_o(alu_ready), .alu_addr_i(a[1]), .alu_data_i(d[1]),
    .mem_valid_i(v[0]), .mem_ready_o(mem_ready), .mem_addr_i(a[0]), .mem_data_i(d[0]),
    .mul_valid_i(v[2]), .mul_ready_o(mul_ready), .mul_addr_i(a[2]), .mul_data_i(d[2]),
    .writeEn_o(we), .dest_addr_o(dest), .writeVal_o(val)
  );

  typedef struct {
    int            cyc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t                sb [$];
  logic [AW+DW-1:0]    mq [3][$];
  int                  starve [3];
  logic                acc [3];
  logic                exp_we;
  logic [AW-1:0]       hold_dest;
  logic [DW-1:0]       hold_val;
  int                  cyc = 0;
  int                  n_pass = 0;
  int                  n_tot = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: every write the DUT presents must be the oldest predicted write, on time.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      check("write_predicted", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("write_cycle", cyc, e.cyc);
        check("write_dest", dest, e.a);
        check("write_val", val, e.d);
        $display("cycle %0d write dest=%0d val=%08h", cyc, dest, val);
      end
    end
  end

  // One cycle: inputs already driven at the falling edge; predict the next rising edge.
  task automatic step();
    logic [AW+DW-1:0] e;
    int w;
    #1;
    check("mem_ready", mem_ready, rst_n && (mq[0].size() < D));
    check("alu_ready", alu_ready, rst_n && (mq[1].size() < D));
    check("mul_ready", mul_ready, rst_n && (mq[2].size() < D));
    for (int s = 0; s < 3; s++) acc[s] = rst_n && !flush && v[s] && (mq[s].size() < D);
    exp_we = 1'b0;
    if (!rst_n || flush) begin
      for (int s = 0; s < 3; s++) begin
        mq[s].delete();
        starve[s] = 0;
      end
      if (!rst_n) begin
        hold_dest = '0;
        hold_val  = '0;
      end
    end else begin
      w = -1;
      for (int s = 0; s < 3; s++) if (w < 0 && mq[s].size() > 0 && starve[s] == SM) w = s;
      for (int s = 0; s < 3; s++) if (w < 0 && mq[s].size() > 0) w = s;
      for (int s = 0; s < 3; s++) begin
        if (mq[s].size() > 0 && s != w) starve[s] = (starve[s] < SM) ? starve[s] + 1 : SM;
        else starve[s] = 0;
      end
      if (w >= 0) begin
        e = mq[w].pop_front();
        hold_dest = e[AW+DW-1:DW];
        hold_val  = e[DW-1:0];
        exp_we    = 1'b1;
        sb.push_back('{cyc: cyc + 1, a: hold_dest, d: hold_val});
      end
      for (int s = 0; s < 3; s++) if (acc[s]) mq[s].push_back({a[s], d[s]});
    end
    @(negedge clk);
    if (!exp_we) begin
      check("idle_we", we, 0);
      check("idle_dest", dest, hold_dest);
      check("idle_val", val, hold_val);
    end
  endtask

  task automatic set_src(input int s, input logic vv, input logic [AW-1:0] aa, input logic [DW-1:0] dd);
    v[s] = vv;
    a[s] = aa;
    d[s] = dd;
  endtask

  task automatic idle(input int n);
    for (int s = 0; s < 3; s++) v[s] = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_all(input int n);
    for (int i = 0; i < n; i++) begin
      for (int s = 0; s < 3; s++) set_src(s, 1'b1, AW'(8 * s + i), 32'hC000_0000 + 32'(16 * s + i));
      step();
    end
  endtask

  initial begin
    int k;
    for (int s = 0; s < 3; s++) begin
      set_src(s, 1'b0, '0, '0);
      starve[s] = 0;
    end
    rst_n = 1'b0;
    flush = 1'b0;
    hold_dest = '0;
    hold_val  = '0;
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;

    // Single ALU write, minimum latency
    set_src(1, 1'b1, 5'd3, 32'hA5);
    step();
    idle(3);

    // All three sources in one cycle: mem, alu, mul
    set_src(0, 1'b1, 5'd2, 32'h22);
    set_src(1, 1'b1, 5'd1, 32'h11);
    set_src(2, 1'b1, 5'd4, 32'h44);
    step();
    idle(5);

    // Starvation: mem streams while mul holds one entry
    set_src(2, 1'b1, 5'd7, 32'h77);
    set_src(0, 1'b1, 5'd9, 32'h9000);
    step();
    v[2] = 1'b0;
    for (int i = 1; i < 10; i++) begin
      set_src(0, 1'b1, 5'd9, 32'h9000 + 32'(i));
      step();
    end
    idle(6);

    // ALU back-pressure while mem saturates; source holds the item until accepted
    k = 0;
    for (int i = 0; i < 20 && k < 3; i++) begin
      set_src(0, 1'b1, 5'd20, 32'hE000 + 32'(i));
      set_src(1, 1'b1, AW'(10 + k), 32'h100 + 32'(k));
      step();
      if (acc[1]) k++;
    end
    check("alu_three_accepted", k, 3);
    idle(10);

    // Flush with full-ish FIFOs
    push_all(3);
    for (int s = 0; s < 3; s++) v[s] = 1'b1;
    flush = 1'b1;
    step();
    idle(4);

    // Reset mid-drain
    push_all(3);
    for (int s = 0; s < 3; s++) v[s] = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    idle(5);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(99) != 0);
      flush = ($urandom_range(39) == 0);
      for (int s = 0; s < 3; s++) set_src(s, ($urandom_range(2) != 0), AW'($urandom), $urandom);
      step();
    end
    rst_n = 1'b1;
    idle(12);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
